// File: rtl/modbus_rtu_rx_fifo.sv
// Modbus RTU receive front-end: 16x oversampling UART, RTU silence framing,
// running CRC-16/Modbus and a byte FIFO that tags the last byte of each frame.
module modbus_rtu_rx_fifo #(
  parameter int DEPTH = 64,
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      baud_div,
  input  logic [1:0]       parity,
  input  logic             stop2,
  input  logic [7:0]       sil_bits,
  input  logic             uart_rx_i,
  output logic [7:0]       rd_data,
  output logic             rd_last,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             frm_done,
  output logic [LEN_W-1:0] frm_len,
  output logic             frm_crc_ok,
  output logic             frm_err,
  output logic             ovf,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2} state_t;
  state_t state, state_nxt;

  logic        rx_s1, rx_s2, rx_d;
  logic [15:0] div_cnt, div_max;
  logic [3:0]  tick_cnt;
  logic        tick, sample, bit_end, par_en;
  logic        start_det, start_ok, data_smp, data_end, par_smp, stop_smp, byte_done;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together at the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx_i;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign div_max = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  assign tick    = (div_cnt >= div_max);
  assign sample  = tick && (tick_cnt == 4'd7);
  assign bit_end = tick && (tick_cnt == 4'd15);
  assign par_en  = parity[0] ^ parity[1];

  // Bit timing is re-phased on every start edge so tick 8 lands mid-bit.
  always_ff @(posedge clk) begin
    if (rst || start_det) begin
      div_cnt  <= 16'd0;
      tick_cnt <= 4'd0;
    end else if (tick) begin
      div_cnt  <= 16'd0;
      tick_cnt <= tick_cnt + 4'd1;
    end else begin
      div_cnt  <= div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: each combinational block assigns a default to every output first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_det) state_nxt = S_START;
      S_START: begin
        if (sample && rx_s2) state_nxt = S_IDLE;
        else if (bit_end)    state_nxt = S_DATA;
      end
      S_DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = par_en ? S_PAR : S_STOP1;
      S_PAR:   if (bit_end) state_nxt = S_STOP1;
      S_STOP1: begin
        if (!stop2 && sample)    state_nxt = S_IDLE;
        else if (stop2 && bit_end) state_nxt = S_STOP2;
      end
      S_STOP2: if (sample) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_det = 1'b0;
    start_ok  = 1'b0;
    data_smp  = 1'b0;
    data_end  = 1'b0;
    par_smp   = 1'b0;
    stop_smp  = 1'b0;
    byte_done = 1'b0;
    case (state)
      S_IDLE:  start_det = rx_d && !rx_s2;
      S_START: start_ok  = sample && !rx_s2;
      S_DATA: begin
        data_smp = sample;
        data_end = bit_end;
      end
      S_PAR:   par_smp = sample;
      S_STOP1: begin
        stop_smp  = sample;
        byte_done = sample && !stop2;
      end
      S_STOP2: begin
        stop_smp  = sample;
        byte_done = sample;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      if (start_ok)      bit_cnt <= 3'd0;
      else if (data_end) bit_cnt <= bit_cnt + 3'd1;
      if (data_smp)      shreg   <= {rx_s2, shreg[7:1]};
    end
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // Frame tracking: silence counter, running CRC/length, error flags, staging byte.
  logic [7:0]       sil_thr, sil_cnt, stg_data;
  logic             sil_hit, end_frame, stg_valid, err_acc, ovf_acc;
  logic [15:0]      crc;
  logic [LEN_W-1:0] len;
  logic             push, push_ok, drop, pop, full, ovf_now;

  assign sil_thr   = (sil_bits == 8'd0) ? 8'd1 : sil_bits;
  assign sil_hit   = ({1'b0, sil_cnt} + 9'd1) >= {1'b0, sil_thr};
  assign end_frame = busy && (state == S_IDLE) && bit_end && sil_hit;
  assign push      = stg_valid && (byte_done || end_frame);
  assign ovf_now   = ovf_acc || drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sil_cnt    <= 8'd0;
      busy       <= 1'b0;
      crc        <= 16'hFFFF;
      len        <= '0;
      err_acc    <= 1'b0;
      ovf_acc    <= 1'b0;
      stg_valid  <= 1'b0;
      stg_data   <= 8'd0;
      frm_done   <= 1'b0;
      frm_len    <= '0;
      frm_crc_ok <= 1'b0;
      frm_err    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      frm_done <= end_frame;
      if (byte_done || end_frame)                 sil_cnt <= 8'd0;
      else if (busy && state == S_IDLE && bit_end) sil_cnt <= sil_cnt + 8'd1;

      if (start_ok)       busy <= 1'b1;
      else if (end_frame) busy <= 1'b0;

      if ((par_smp && (rx_s2 ^ (^shreg) ^ parity[1])) || (stop_smp && !rx_s2))
        err_acc <= 1'b1;
      if (drop) ovf_acc <= 1'b1;

      if (byte_done) begin
        crc       <= crc_step(crc, shreg);
        if (len != '1) len <= len + LEN_W'(1);
        stg_data  <= shreg;
        stg_valid <= 1'b1;
      end

      if (end_frame) begin
        frm_len    <= len;
        frm_err    <= err_acc;
        ovf        <= ovf_now;
        frm_crc_ok <= (crc == 16'h0000) && (len >= LEN_W'(4)) && !err_acc && !ovf_now;
        crc        <= 16'hFFFF;
        len        <= '0;
        err_acc    <= 1'b0;
        ovf_acc    <= 1'b0;
        stg_valid  <= 1'b0;
      end
    end
  end

  // Byte FIFO; a pop in the same cycle frees the slot for a push into a full FIFO.
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;

  assign pop     = rd_valid && rd_ready;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign push_ok = push && (!full || pop);
  assign drop    = push && !push_ok;

  // NOTE: the storage array has no reset; cnt alone says which entries are
  // valid, which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {end_frame, stg_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_valid          = (cnt != '0);
  assign {rd_last, rd_data} = rd_valid ? mem[rd_ptr] : 9'd0;
endmodule

// File: tb/tb_modbus_rtu_rx_fifo.sv
// Bench for modbus_rtu_rx_fifo: frames are serialised here, expected bytes and
// frame status are queued at send time and checked by independent monitors.
`timescale 1ns/1ps
module tb_modbus_rtu_rx_fifo;
  localparam int LEN_W = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd2;
  logic [1:0]  parity = 2'd0;
  logic        stop2 = 1'b0;
  logic [7:0]  sil_bits = 8'd35;
  logic        line = 1'b1;
  logic        en4 = 1'b0;
  logic        uart4;
  logic        rd_ready = 1'b0;
  logic        rd_ready4 = 1'b0;

  logic [7:0]       rd_data, rd_data4;
  logic             rd_last, rd_valid, frm_done, frm_crc_ok, frm_err, ovf, busy;
  logic             rd_last4, rd_valid4, frm_done4, frm_crc_ok4, frm_err4, ovf4, busy4;
  logic [LEN_W-1:0] frm_len, frm_len4;

  assign uart4 = en4 ? line : 1'b1;

  always #5 clk = ~clk;

  modbus_rtu_rx_fifo #(.DEPTH(64), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity(parity), .stop2(stop2),
    .sil_bits(sil_bits), .uart_rx_i(line), .rd_data(rd_data), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .frm_done(frm_done), .frm_len(frm_len),
    .frm_crc_ok(frm_crc_ok), .frm_err(frm_err), .ovf(ovf), .busy(busy)
  );

  modbus_rtu_rx_fifo #(.DEPTH(4), .LEN_W(LEN_W)) dut4 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity(parity), .stop2(stop2),
    .sil_bits(sil_bits), .uart_rx_i(uart4), .rd_data(rd_data4), .rd_last(rd_last4),
    .rd_valid(rd_valid4), .rd_ready(rd_ready4), .frm_done(frm_done4), .frm_len(frm_len4),
    .frm_crc_ok(frm_crc_ok4), .frm_err(frm_err4), .ovf(ovf4), .busy(busy4)
  );

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             ok;
    logic             err;
    logic             ovf;
  } stat_t;

  logic [8:0]  exp_q[$];
  stat_t       stat_q[$];
  logic [7:0]  seg[$];
  logic [7:0]  cur[$];
  bit          cur_err = 1'b0;
  bit          ign = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          bt = 32;
  int          done4_cnt = 0;
  bit          mon_stall = 1'b0;
  logic [8:0]  mon_held = 9'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (frm_done4) done4_cnt <= done4_cnt + 1;

  // Output monitor: pops expected bytes / frame status whenever the DUT presents them.
  initial begin
    stat_t s;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (mon_stall && !ign) begin
        check("hold_valid", rd_valid, 1);
        check("hold_data", {rd_last, rd_data}, mon_held);
      end
      if (frm_done) begin
        if (stat_q.size() == 0) check("unexpected_frm_done", frm_done, 0);
        else begin
          s = stat_q.pop_front();
          check("frm_len", frm_len, s.len);
          check("frm_crc_ok", frm_crc_ok, s.ok);
          check("frm_err", frm_err, s.err);
          check("frm_ovf", ovf, s.ovf);
        end
      end
      rd_ready = ($urandom_range(0, 3) != 0);
      if (rd_valid && rd_ready && !ign) begin
        if (exp_q.size() == 0) check("unexpected_byte", rd_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("rd_byte", {rd_last, rd_data}, e);
        end
      end
      mon_stall = rd_valid && !rd_ready && !ign;
      mon_held  = {rd_last, rd_data};
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference CRC-16/Modbus: message bits fed LSB-first into the reflected register.
  function automatic logic [15:0] crc_model(input bit use_seg, input int m);
    logic [15:0] c;
    logic [7:0]  d;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < m; i++) begin
      d = use_seg ? seg[i] : cur[i];
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic set_baud(input logic [15:0] bd);
    baud_div = bd;
    bt = 16 * ((bd == 16'd0) ? 1 : int'(bd));
  endtask

  task automatic send_bit(input logic v);
    line = v;
    repeat (bt) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (parity == 2'd1 || parity == 2'd2) send_bit((^b) ^ (parity == 2'd2) ^ bad_par);
    send_bit(!bad_stop);
    if (stop2) send_bit(1'b1);
    else if (bad_stop) send_bit(1'b1);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic close_frame();
    stat_t s;
    int    n;
    n     = cur.size();
    s.len = (n > 511) ? '1 : LEN_W'(n);
    s.err = cur_err;
    s.ovf = 1'b0;
    s.ok  = 1'b0;
    if (n >= 4 && !cur_err) s.ok = (crc_model(1'b0, n - 2) == {cur[n-1], cur[n-2]});
    stat_q.push_back(s);
    cur.delete();
    cur_err = 1'b0;
  endtask

  // Sends the bytes in seg; 'ends' says whether the trailing gap closes the frame.
  task automatic send_seg(input int bad_idx, input bit bad_is_stop, input bit ends, input int gap);
    bit par_on;
    par_on = (parity == 2'd1 || parity == 2'd2);
    for (int i = 0; i < seg.size(); i++) begin
      exp_q.push_back({ends && (i == seg.size() - 1), seg[i]});
      cur.push_back(seg[i]);
    end
    if (bad_idx >= 0 && (bad_is_stop || par_on)) cur_err = 1'b1;
    if (ends) close_frame();
    for (int i = 0; i < seg.size(); i++)
      send_byte(seg[i], (bad_idx == i) && !bad_is_stop, (bad_idx == i) && bad_is_stop);
    idle_bits(gap);
  endtask

  task automatic load8(input logic [63:0] v);
    seg.delete();
    for (int i = 7; i >= 0; i--) seg.push_back(v[i*8 +: 8]);
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    while ((stat_q.size() != 0 || exp_q.size() != 0) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("drain_in_time", k < 20000, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_last"}, rd_last, 0);
    check({tag, "_frm_done"}, frm_done, 0);
    check({tag, "_frm_len"}, frm_len, 0);
    check({tag, "_frm_crc_ok"}, frm_crc_ok, 0);
    check({tag, "_frm_err"}, frm_err, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  localparam logic [63:0] FRAME_A = 64'h01050000FF008C3A;
  localparam logic [63:0] FRAME_X = 64'h01050000FF008C3B;
  localparam logic [63:0] FRAME_1 = 64'h0101000000_01FDCA;
  localparam logic [63:0] FRAME_2 = 64'h0102000000_01B9CA;

  initial begin
    logic [63:0] fa;
    logic [7:0]  exp4;
    logic [15:0] c;
    int          base, k, nseg, bad_idx;
    bit          ends;

    set_baud(16'd2);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    idle_bits(2);

    // Reference frame, then the same frame with a corrupted CRC high byte.
    load8(FRAME_A); send_seg(-1, 0, 1, 38);
    set_baud(16'd1);
    load8(FRAME_X); send_seg(-1, 0, 1, 38);

    // Even parity: bad then good parity bit on a single byte, then odd parity frame.
    wait_quiet();
    parity = 2'd1;
    seg.delete(); seg.push_back(8'h01); send_seg(0, 0, 1, 38);
    seg.delete(); seg.push_back(8'h01); send_seg(-1, 0, 1, 38);
    wait_quiet();
    parity = 2'd2; stop2 = 1'b1;
    load8(FRAME_A); send_seg(-1, 0, 1, 38);
    wait_quiet();
    parity = 2'd0; stop2 = 1'b0;

    // Overflow into the 4-deep instance with nothing being read.
    base = done4_cnt;
    en4 = 1'b1;
    load8(FRAME_A); send_seg(-1, 0, 1, 38);
    k = 0;
    while (done4_cnt == base && k < 5000) begin @(negedge clk); k++; end
    en4 = 1'b0;
    check("dut4_done_count", done4_cnt - base, 1);
    check("dut4_frm_len", frm_len4, 8);
    check("dut4_ovf", ovf4, 1);
    check("dut4_crc_ok", frm_crc_ok4, 0);
    check("dut4_frm_err", frm_err4, 0);
    fa = FRAME_A;
    for (int i = 0; i < 4; i++) begin
      exp4 = fa[(7-i)*8 +: 8];
      check("dut4_valid", rd_valid4, 1);
      check("dut4_byte", {rd_last4, rd_data4}, {1'b0, exp4});
      rd_ready4 = 1'b1;
      @(negedge clk);
      rd_ready4 = 1'b0;
    end
    check("dut4_empty", rd_valid4, 0);

    // Two frames with a 40 bit-time gap, then the same pair with a 20 bit-time gap.
    load8(FRAME_1); send_seg(-1, 0, 1, 40);
    load8(FRAME_2); send_seg(-1, 0, 1, 40);
    load8(FRAME_1); send_seg(-1, 0, 0, 20);
    load8(FRAME_2); send_seg(-1, 0, 1, 40);

    // Reset in the middle of a byte discards the frame.
    wait_quiet();
    ign = 1'b1;
    send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    line = 1'b0;
    repeat (bt / 2) @(negedge clk);
    rst  = 1'b1;
    line = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    ign = 1'b0;
    idle_bits(5);
    load8(FRAME_A); send_seg(-1, 0, 1, 38);

    // Randomised frames over baud, parity, stop bits, silence threshold and errors.
    for (int it = 0; it < 6; it++) begin
      wait_quiet();
      set_baud(16'($urandom_range(0, 1)));
      parity   = 2'($urandom_range(0, 3));
      stop2    = 1'($urandom_range(0, 1));
      sil_bits = 8'($urandom_range(8, 20));
      idle_bits(2);
      nseg = $urandom_range(1, 2);
      for (int s = 0; s < nseg; s++) begin
        ends = (s == nseg - 1);
        seg.delete();
        k = $urandom_range(2, 6);
        for (int i = 0; i < k; i++) seg.push_back(8'($urandom_range(0, 255)));
        if (ends && $urandom_range(0, 3) != 0) begin
          c = crc_model(1'b1, seg.size());
          seg.push_back(c[7:0]);
          seg.push_back(c[15:8]);
        end
        bad_idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, seg.size() - 1) : -1;
        send_seg(bad_idx, 1'($urandom_range(0, 1)), ends,
                 ends ? int'(sil_bits) + $urandom_range(3, 6) : $urandom_range(0, int'(sil_bits) - 4));
      end
    end

    wait_quiet();
    repeat (10) @(negedge clk);
    check("final_fifo_empty", rd_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/modbus_rtu_rx_fifo.md
# modbus_rtu_rx_fifo

Parametrised Modbus RTU receive front-end: oversampling UART receiver with configurable parity/stop bits, RTU inter-frame silence detection, on-the-fly CRC-16 check and a byte FIFO that tags the last byte of each frame. It sits between the UART_RX pin and the Modbus controller in top_modbus_converter. It is the successor to the receive half of uart_bridge, adding buffering, back-pressure and per-frame status.

## Interface
- DEPTH, 64: FIFO entries (9 bit: {last, data}); power of two, ≥4.
- LEN_W, 9: width of frame byte counter; saturates at all-ones.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- baud_div  in  16  clk cycles per 1/16-bit tick; 0 treated as 1.
- parity  in  2  0 none, 1 even, 2 odd, 3 none.
- stop2  in  1  1 = two stop bits checked.
- sil_bits  in  8  idle bit-times ending a frame (35 = 3.5 chars); 0 treated as 1.
- uart_rx_i  in  1  serial input, idle high.
- rd_data  out  8  FIFO head byte.
- rd_last  out  1  head byte is last of its frame.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  pop when rd_valid & rd_ready.
- frm_done  out  1  one-cycle pulse at frame end.
- frm_len  out  LEN_W  bytes received in frame, including CRC; valid with frm_done.
- frm_crc_ok  out  1  CRC residue zero, len ≥ 4, no parity/framing/overflow error; valid with frm_done.
- frm_err  out  1  any parity/framing error in frame; valid with frm_done.
- ovf  out  1  byte(s) dropped due to full FIFO in frame; valid with frm_done.
- busy  out  1  receiver inside a frame (first start bit to frm_done).

## Operation
- uart_rx_i through 2-FF synchroniser; all logic uses synchronised value.
- Tick generator: counter 0..baud_div-1, tick on wrap; reset to 0 on start-bit detect.
- Bit FSM: IDLE → START (falling edge seen) → DATA (8 bits, LSB first) → PAR (if parity 1/2) → STOP1 → STOP2 (if stop2) → IDLE. Sample at tick 8 of each bit; START aborts to IDLE if sample is 1 (glitch, no byte).
- Parity error: received parity ≠ computed. Framing error: any stop sample 0. Erroneous bytes still stored and counted; frame flag frm_err set.
- Byte completion (after last stop sample): CRC-16/Modbus (poly 0xA001 reflected, init 0xFFFF) updated with byte; frm_len increments; byte goes to staging register. If staging already held a byte, that byte is pushed with last=0.
- Silence counter: clears at each byte completion, increments per bit-time (16 ticks) while IDLE and busy. At count == sil_bits: staged byte pushed with last=1, frm_done pulses, status latched, CRC reset to 0xFFFF, len cleared, busy deasserts.
- Start bit during silence count below threshold continues the same frame.
- Push when FIFO full: byte dropped, ovf set for frame, frm_crc_ok forced 0; dropped last byte means no rd_last in FIFO for that frame.
- Simultaneous push and pop on full FIFO: pop first, push accepted.
- frm_crc_ok = (crc == 0) & (len ≥ 4) & !frm_err & !ovf.

## Timing
- Reset: rd_valid 0, rd_data 0, rd_last 0, frm_done 0, frm_len 0, frm_crc_ok 0, frm_err 0, ovf 0, busy 0; FIFO empty, FSM IDLE, CRC 0xFFFF. Reset mid-frame discards frame, no frm_done.
- Input-to-detect latency: 2 cycles (synchroniser).
- Byte visible on rd_data: last byte of frame appears 1 cycle after frm_done is registered (staging push same cycle as frm_done, rd_valid next cycle); non-last bytes appear 1 cycle after following byte completes.
- FIFO is first-word registered: rd_data/rd_last stable while rd_valid & !rd_ready.
- frm_len/frm_crc_ok/frm_err/ovf hold until next frm_done or reset.
- CRC updated combinationally in one cycle over 8 bits.

## Test plan
- baud_div 54, parity 0: frame 01 05 00 00 FF 00 8C 3A, 35 bit-times idle → 8 bytes popped in order, rd_last only on 3A, frm_len 8, frm_crc_ok 1, frm_err 0.
- Same frame with CRC hi 3B → frm_done, frm_len 8, frm_crc_ok 0, data still delivered.
- parity 1 (even), byte 0x01 sent with parity bit 0 → frm_err 1, frm_crc_ok 0; with correct parity 1 → frm_err 0.
- DEPTH 4, rd_ready 0, 8-byte frame → 4 bytes stored, ovf 1, frm_len 8, no rd_last in FIFO; drain returns 01 05 00 00.
- Two frames 01 01 00 00 00 01 FD CA and 01 02 00 00 00 01 B9 CA with 40 bit-times gap → two frm_done pulses, both ok; 20 bit-times gap → one frame, len 16, crc_ok 0.
- rst asserted mid-byte of frame → all outputs reset values, next clean frame received ok.
